// File: rtl/demux_buffered_pkg.sv
// Shared definitions for the buffered operation-classifying demultiplexer.
// Holds the default widths, the packed queue entry layout for those
// defaults, and small pure helpers (ceiling log2, one-hot of a select).
package demux_buffered_pkg;

  localparam int DEF_SEL_W  = 4;
  localparam int DEF_DATA_W = 16;

  // One queued transaction at the default widths: destination then payload.
  typedef struct packed {
    logic [DEF_SEL_W-1:0]  sel;
    logic [DEF_DATA_W-1:0] data;
  } entry_t;

  // Ceiling log2, usable in parameter and port width expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  // One-hot of a select at the default width.
  function automatic logic [(1<<DEF_SEL_W)-1:0] onehot_of(input logic [DEF_SEL_W-1:0] sel);
    logic [(1<<DEF_SEL_W)-1:0] result;
    result      = '0;
    result[sel] = 1'b1;
    return result;
  endfunction

endpackage

// File: rtl/demux_buffered_onehot_decoder.sv
// Combinational SEL_W -> 2**SEL_W one-hot decoder with enable.
// Ports:
//   en      - when low, every output bit is zero
//   sel     - binary channel index
//   onehot  - exactly one bit set (bit sel) when en is high
module demux_buffered_onehot_decoder #(
  parameter int SEL_W = 4
) (
  input  logic                  en,
  input  logic [SEL_W-1:0]      sel,
  output logic [(1<<SEL_W)-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[sel] = 1'b1;
    end
  end

endmodule

// File: rtl/demux_buffered.sv
// Buffered demultiplexer between instruction decode and the execution units.
// Transactions {in_sel, in_data} arrive over valid/ready and are queued in an
// in-order FIFO of DEPTH entries. The head is presented with its payload, its
// binary select and a one-hot channel strobe. Transactions aimed at a channel
// disabled in chan_mask (sampled at accept time) are discarded and counted in
// a saturating drop counter.
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   in_valid/in_ready    - input handshake; in_ready depends only on state
//   in_sel, in_data      - destination channel and payload
//   chan_mask            - per-channel enable, 1 = enabled
//   out_valid/out_ready  - output handshake for the FIFO head
//   out_onehot, out_sel  - head destination as one-hot and binary (0 if empty)
//   out_data             - head payload (0 if empty)
//   count                - number of entries held
//   drop_cnt             - saturating count of masked drops
module demux_buffered
  import demux_buffered_pkg::*;
#(
  parameter int SEL_W  = DEF_SEL_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [SEL_W-1:0]           in_sel,
  input  logic [DATA_W-1:0]          in_data,
  input  logic [(1<<SEL_W)-1:0]      chan_mask,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [(1<<SEL_W)-1:0]      out_onehot,
  output logic [SEL_W-1:0]           out_sel,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [CNT_W-1:0]           drop_cnt
);

  localparam int PTR_W    = clog2(DEPTH);
  localparam int OCC_W    = clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] FULL_LVL = OCC_W'(DEPTH);

  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] data;
  } slot_t;

  slot_t              mem_q [DEPTH];
  slot_t              mem_d [DEPTH];
  logic [PTR_W-1:0]   wptr_q, wptr_d;
  logic [PTR_W-1:0]   rptr_q, rptr_d;
  logic [OCC_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

  logic  accept, store, drop, pop;
  slot_t head;

  // Ready is a function of registered occupancy only, so a full FIFO refuses
  // new work even when the consumer is draining in the same cycle.
  assign in_ready  = !reset && (count_q != FULL_LVL);
  assign out_valid = (count_q != '0);
  assign head      = mem_q[rptr_q];

  // Mask is looked up once, at accept; stored entries never see it again.
  always_comb begin
    accept     = in_valid && in_ready;
    store      = accept && chan_mask[in_sel];
    drop       = accept && !chan_mask[in_sel];
    pop        = out_valid && out_ready;
    mem_d      = mem_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    drop_cnt_d = drop_cnt_q;
    if (store) begin
      mem_d[wptr_q] = '{sel: in_sel, data: in_data};
      wptr_d        = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    if (store && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!store && pop) begin
      count_d = count_q - 1'b1;
    end
    if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  // Storage is left unreset: stale slots are never visible because the head
  // buses are gated by out_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
    end
    mem_q <= mem_d;
  end

  assign out_sel  = out_valid ? head.sel  : '0;
  assign out_data = out_valid ? head.data : '0;
  assign count    = count_q;
  assign drop_cnt = drop_cnt_q;

  demux_buffered_onehot_decoder #(
    .SEL_W (SEL_W)
  ) u_decoder (
    .en     (out_valid),
    .sel    (out_sel),
    .onehot (out_onehot)
  );

endmodule

// File: tb/tb_demux_buffered.sv
// Scoreboard bench for demux_buffered at default parameters (SEL_W=4,
// DATA_W=16, DEPTH=2, CNT_W=8). Inputs change 1 ns after the rising edge;
// a negedge monitor compares the outputs with a reference queue and then
// decides which handshakes the coming edge will complete.
module tb_demux_buffered;

  localparam int SEL_W  = 4;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 2;
  localparam int CNT_W  = 8;
  localparam int OUT_N  = 1 << SEL_W;

  typedef struct {
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [SEL_W-1:0]  in_sel;
  logic [DATA_W-1:0] in_data;
  logic [OUT_N-1:0]  chan_mask;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_N-1:0]  out_onehot;
  logic [SEL_W-1:0]  out_sel;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        count;
  logic [CNT_W-1:0]  drop_cnt;

  exp_t expQ[$];
  int   total;
  int   bad;
  int   modelDrop;
  int   stallCnt;
  bit   monitorOn;
  bit   streaming;

  demux_buffered #(
    .SEL_W  (SEL_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .in_data    (in_data),
    .chan_mask  (chan_mask),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_onehot (out_onehot),
    .out_sel    (out_sel),
    .out_data   (out_data),
    .count      (count),
    .drop_cnt   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts one comparison and reports it if the DUT disagrees.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Offers one transaction and holds it until the DUT takes it.
  task automatic applyStimulus(input logic [SEL_W-1:0] sel, input logic [DATA_W-1:0] data);
    int waits;
    in_sel   = sel;
    in_data  = data;
    in_valid = 1'b1;
    waits    = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      stallCnt = stallCnt + 1;
      waits    = waits + 1;
      if (waits > 50) begin
        checkOutput("push_timeout", 32'(waits), 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int cyc;
    cyc = 0;
    while (expQ.size() != 0 || count != 0) begin
      @(negedge clk);
      cyc = cyc + 1;
      if (cyc > 100) begin
        checkOutput("drain_timeout", 32'(expQ.size()), 32'd0);
        break;
      end
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
    end
    #1;
  endtask

  // Reference model: checks the present outputs, then applies the handshakes
  // that the next rising edge will complete.
  always @(negedge clk) begin
    logic [OUT_N-1:0] expOh;
    if (monitorOn) begin
      checkOutput("count", 32'(count), 32'(expQ.size()));
      checkOutput("out_valid", 32'(out_valid), 32'(expQ.size() != 0));
      checkOutput("in_ready", 32'(in_ready), 32'(!reset && expQ.size() != DEPTH));
      checkOutput("drop_cnt", 32'(drop_cnt), 32'(modelDrop));
      if (streaming) checkOutput("stream_count_le1", 32'(count <= 1), 32'd1);
      if (expQ.size() != 0) begin
        expOh = '0;
        expOh[expQ[0].sel] = 1'b1;
        checkOutput("out_sel", 32'(out_sel), 32'(expQ[0].sel));
        checkOutput("out_data", 32'(out_data), 32'(expQ[0].data));
        checkOutput("out_onehot", 32'(out_onehot), 32'(expOh));
      end else begin
        checkOutput("empty_buses", {out_onehot, out_data}, 32'd0);
        checkOutput("empty_sel", 32'(out_sel), 32'd0);
      end
      if (reset) begin
        expQ.delete();
        modelDrop = 0;
      end else begin
        logic canPush;
        canPush = (expQ.size() != DEPTH);
        if (out_ready && expQ.size() != 0) void'(expQ.pop_front());
        if (in_valid && canPush) begin
          if (chan_mask[in_sel]) expQ.push_back('{sel: in_sel, data: in_data});
          else if (modelDrop < 255) modelDrop = modelDrop + 1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    total     = 0;
    bad       = 0;
    modelDrop = 0;
    stallCnt  = 0;
    monitorOn = 1'b0;
    streaming = 1'b0;
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_sel    = '0;
    in_data   = '0;
    chan_mask = 16'hFFFF;
    out_ready = 1'b0;

    // Reset held two cycles with in_valid asserted.
    @(posedge clk);
    #1;
    monitorOn = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_onehot", 32'(out_onehot), 32'd0);
    checkOutput("rst_drop", 32'(drop_cnt), 32'd0);
    checkOutput("rst_count", 32'(count), 32'd0);
    reset    = 1'b0;
    in_valid = 1'b0;
    idleCycles(1);

    // Single pass-through, consumer always ready.
    out_ready = 1'b1;
    applyStimulus(4'd5, 16'hBEEF);
    checkOutput("single_onehot", 32'(out_onehot), 32'h0020);
    checkOutput("single_data", 32'(out_data), 32'hBEEF);
    idleCycles(1);
    checkOutput("single_count_back", 32'(count), 32'd0);

    // Fill to full with the consumer stalled, then drain in order.
    out_ready = 1'b0;
    applyStimulus(4'd0, 16'h0001);
    applyStimulus(4'd15, 16'h8000);
    checkOutput("full_count", 32'(count), 32'd2);
    checkOutput("full_in_ready", 32'(in_ready), 32'd0);
    in_sel   = 4'd7;
    in_data  = 16'h0777;
    in_valid = 1'b1;
    idleCycles(3);
    checkOutput("stall_count", 32'(count), 32'd2);
    checkOutput("stall_head", 32'(out_onehot), 32'h0001);
    out_ready = 1'b1;
    idleCycles(1);
    checkOutput("drain_second", 32'(out_onehot), 32'h8000);
    checkOutput("ready_after_pop", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    waitDrain();
    @(posedge clk);
    #1;

    // Masked channel 3: dropped and counted, then saturation.
    chan_mask = 16'hFFF7;
    applyStimulus(4'd3, 16'h1234);
    checkOutput("mask_no_valid", 32'(out_valid), 32'd0);
    checkOutput("mask_drop1", 32'(drop_cnt), 32'd1);
    in_sel   = 4'd3;
    in_valid = 1'b1;
    idleCycles(300);
    in_valid = 1'b0;
    idleCycles(1);
    checkOutput("drop_saturate", 32'(drop_cnt), 32'd255);
    chan_mask = 16'hFFFF;

    // Back-to-back stream over every channel, pointers wrap several times.
    stallCnt  = 0;
    streaming = 1'b1;
    for (int i = 0; i < OUT_N; i++) begin
      applyStimulus(SEL_W'(i), DATA_W'(16'hA000 + i));
    end
    checkOutput("stream_stalls", 32'(stallCnt), 32'd0);
    waitDrain();
    streaming = 1'b0;
    @(posedge clk);
    #1;

    // Reset with two buffered entries, then a clean transaction.
    out_ready = 1'b0;
    applyStimulus(4'd1, 16'h1111);
    applyStimulus(4'd2, 16'h2222);
    checkOutput("pre_rst_count", 32'(count), 32'd2);
    reset = 1'b1;
    idleCycles(1);
    reset = 1'b0;
    checkOutput("mid_rst_count", 32'(count), 32'd0);
    checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    applyStimulus(4'd9, 16'h0909);
    checkOutput("post_rst_onehot", 32'(out_onehot), 32'h0200);
    checkOutput("post_rst_data", 32'(out_data), 32'h0909);
    waitDrain();
    idleCycles(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
